// File: rtl/libtech.sv
// libtech: shared types and constants for the DRAM bring-up path.
//   dram_seq_state_type  - sequencer state encoding, also exported on seq_state
//   DRAM_SEQ_RETRY_MAX   - default number of calibration retries after the first attempt
//   seq_ctrl_rst         - memory controller reset level for a given sequencer state
package libtech;

    typedef enum bit [2:0] {
        PWRUP     = 3'd0,
        WAIT_IDLY = 3'd1,
        RST_HOLD  = 3'd2,
        CALIB     = 3'd3,
        DONE      = 3'd4,
        FAIL      = 3'd5
    } dram_seq_state_type;

    localparam int DRAM_SEQ_RETRY_MAX = 3;

    // The controller only runs out of reset while calibrating or calibrated;
    // every other state, including any unknown encoding, holds it in reset.
    function automatic logic seq_ctrl_rst(dram_seq_state_type s);
        return !((s == CALIB) || (s == DONE));
    endfunction

endpackage

// File: rtl/dram_sync2.sv
// dram_sync2: generic two-flop synchronizer for a single-bit asynchronous input.
//   clk      in  destination clock
//   rst      in  asynchronous active-high reset, clears both flops
//   async_in in  signal from another clock domain or a pad
//   sync_out out async_in retimed to clk, two cycles of latency
module dram_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to settle
    // before anything downstream looks at the value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/dram_bringup_seq.sv
// dram_bringup_seq: bring-up and recovery sequencer for the DRAM controller/PHY.
//   pll_clk0_b    in  sequencer clock (DRAM clk0, buffered)
//   rst_tmp       in  asynchronous active-high reset
//   idelay_rdy    in  IDELAYCTRL ready, asynchronous, synchronized internally
//   phy_init_done in  PHY calibration complete (clk0 domain)
//   soft_rst      in  single-cycle request to rerun calibration
//   ctrl_rst      out controller/PHY reset, active-high
//   calib_done    out calibration complete and stable
//   calib_fail    out calibration retries exhausted
//   retry_cnt     out retries consumed in the current bring-up
//   seq_state     out current state encoding for debug
module dram_bringup_seq
    import libtech::*;
#(
    parameter int PWRUP_CYCLES = 2048,
    parameter int RST_CYCLES   = 64,
    parameter int INIT_TIMEOUT = 1048576,
    parameter int MAX_RETRY    = DRAM_SEQ_RETRY_MAX,
    parameter int CNT_W        = 24
) (
    input  logic                           pll_clk0_b,
    input  logic                           rst_tmp,
    input  logic                           idelay_rdy,
    input  logic                           phy_init_done,
    input  logic                           soft_rst,
    output logic                           ctrl_rst,
    output logic                           calib_done,
    output logic                           calib_fail,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
    output logic [2:0]                     seq_state
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    dram_seq_state_type state;
    dram_seq_state_type next_state;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] next_retry;
    logic               restart;
    logic               idly_s;

    dram_sync2 u_idly_sync (
        .clk      (pll_clk0_b),
        .rst      (rst_tmp),
        .async_in (idelay_rdy),
        .sync_out (idly_s)
    );

    assign seq_state = state;

    // Next-state and retry bookkeeping. soft_rst is checked first wherever it
    // applies so a rerun request always beats idelay loss, calibration result
    // and timeout; in CALIB a done and a timeout in the same cycle resolve to DONE.
    // restart re-arms the counter when soft_rst arrives while already in RST_HOLD.
    always_comb begin
        next_state = state;
        next_retry = retry_cnt;
        restart    = 1'b0;
        case (state)
            PWRUP: begin
                if (cnt == CNT_W'(PWRUP_CYCLES - 1))
                    next_state = WAIT_IDLY;
            end
            WAIT_IDLY: begin
                if (idly_s)
                    next_state = RST_HOLD;
            end
            RST_HOLD: begin
                if (soft_rst)
                    restart = 1'b1;
                else if (cnt == CNT_W'(RST_CYCLES - 1))
                    next_state = CALIB;
            end
            CALIB: begin
                if (soft_rst)
                    next_state = RST_HOLD;
                else if (!idly_s)
                    next_state = WAIT_IDLY;
                else if (phy_init_done)
                    next_state = DONE;
                else if (cnt == CNT_W'(INIT_TIMEOUT - 1)) begin
                    if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                        next_state = RST_HOLD;
                        next_retry = retry_cnt + RETRY_W'(1);
                    end else begin
                        next_state = FAIL;
                    end
                end
            end
            DONE: begin
                if (soft_rst) begin
                    next_state = RST_HOLD;
                    next_retry = '0;
                end else if (!idly_s)
                    next_state = WAIT_IDLY;
                else if (!phy_init_done)
                    next_state = RST_HOLD;
            end
            FAIL: begin
                if (soft_rst) begin
                    next_state = RST_HOLD;
                    next_retry = '0;
                end
            end
            default: begin
                next_state = PWRUP;
            end
        endcase
    end

    // State, cycle counter and outputs. Outputs are computed from next_state so
    // they change on the same edge as the state they belong to. The counter
    // restarts on every transition, so it always measures time spent in the
    // current state.
    always_ff @(posedge pll_clk0_b or posedge rst_tmp) begin
        if (rst_tmp) begin
            state      <= PWRUP;
            cnt        <= '0;
            retry_cnt  <= '0;
            ctrl_rst   <= 1'b1;
            calib_done <= 1'b0;
            calib_fail <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= ((next_state != state) || restart) ? '0 : cnt + CNT_W'(1);
            retry_cnt  <= next_retry;
            ctrl_rst   <= seq_ctrl_rst(next_state);
            calib_done <= (next_state == DONE);
            calib_fail <= (next_state == FAIL);
        end
    end

endmodule

// File: tb/tb_dram_bringup_seq.sv
// tb_dram_bringup_seq: directed self-checking bench for dram_bringup_seq with
// shortened timing (PWRUP 16, RST 8, INIT_TIMEOUT 100, MAX_RETRY 2).
module tb_dram_bringup_seq;

    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_RST   = 3'd2;
    localparam logic [2:0] S_CALIB = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;

    logic       pll_clk0_b = 1'b0;
    logic       rst_tmp;
    logic       idelay_rdy;
    logic       phy_init_done;
    logic       soft_rst;
    logic       ctrl_rst;
    logic       calib_done;
    logic       calib_fail;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    int checks   = 0;
    int failures = 0;

    dram_bringup_seq #(
        .PWRUP_CYCLES (16),
        .RST_CYCLES   (8),
        .INIT_TIMEOUT (100),
        .MAX_RETRY    (2),
        .CNT_W        (24)
    ) dut (
        .pll_clk0_b    (pll_clk0_b),
        .rst_tmp       (rst_tmp),
        .idelay_rdy    (idelay_rdy),
        .phy_init_done (phy_init_done),
        .soft_rst      (soft_rst),
        .ctrl_rst      (ctrl_rst),
        .calib_done    (calib_done),
        .calib_fail    (calib_fail),
        .retry_cnt     (retry_cnt),
        .seq_state     (seq_state)
    );

    // Free-running 100 MHz-style clock.
    always #5 pll_clk0_b = ~pll_clk0_b;

    // Last-resort guard so a stuck run still ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n clock edges, sampling/driving 1 time unit after each edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pll_clk0_b);
            #1;
        end
    endtask

    // Wait (bounded) until seq_state equals s.
    task automatic wait_state(input logic [2:0] s, input int limit, output bit ok);
        ok = (seq_state == s);
        for (int i = 0; i < limit && !ok; i++) begin
            tick(1);
            ok = (seq_state == s);
        end
    endtask

    // Count consecutive samples (starting now) in which seq_state equals s.
    task automatic count_state(input logic [2:0] s, input int limit, output int n);
        n = 0;
        while (seq_state == s && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_tmp = 1'b1; idelay_rdy = 1'b0; phy_init_done = 1'b0; soft_rst = 1'b0;
        tick(3);
        checks++; if (ctrl_rst !== 1'b1) begin failures++; $display("[TB] FAIL reset_ctrl_rst: got %b want 1", ctrl_rst); end
        checks++; if (calib_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_calib_done: got %b want 0", calib_done); end
        checks++; if (calib_fail !== 1'b0) begin failures++; $display("[TB] FAIL reset_calib_fail: got %b want 0", calib_fail); end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("[TB] FAIL reset_retry_cnt: got %0d want 0", retry_cnt); end
        checks++; if (seq_state !== S_PWRUP) begin failures++; $display("[TB] FAIL reset_state: got %0d want %0d", seq_state, S_PWRUP); end
    endtask

    task automatic test_nominal;
        int n;
        idelay_rdy = 1'b1;
        tick(1);
        rst_tmp = 1'b0;
        n = 0;
        while (ctrl_rst === 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        checks++; if (n < 25 || n > 27) begin failures++; $display("[TB] FAIL nominal_ctrl_rst_fall: got cycle %0d want 25..27", n); end
        checks++; if (seq_state !== S_CALIB) begin failures++; $display("[TB] FAIL nominal_calib_state: got %0d want %0d", seq_state, S_CALIB); end
        tick(40);
        checks++; if (calib_done !== 1'b0) begin failures++; $display("[TB] FAIL nominal_done_early: got %b want 0", calib_done); end
        phy_init_done = 1'b1;
        tick(1);
        checks++; if (calib_done !== 1'b1) begin failures++; $display("[TB] FAIL nominal_calib_done: got %b want 1", calib_done); end
        checks++; if (seq_state !== S_DONE) begin failures++; $display("[TB] FAIL nominal_done_state: got %0d want %0d", seq_state, S_DONE); end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("[TB] FAIL nominal_retry: got %0d want 0", retry_cnt); end
        checks++; if (ctrl_rst !== 1'b0) begin failures++; $display("[TB] FAIL nominal_ctrl_rst: got %b want 0", ctrl_rst); end
    endtask

    task automatic test_timeout_retries;
        int n;
        soft_rst = 1'b1; phy_init_done = 1'b0;
        tick(1);
        soft_rst = 1'b0;
        checks++; if (seq_state !== S_RST) begin failures++; $display("[TB] FAIL to_soft_rst_state: got %0d want %0d", seq_state, S_RST); end
        checks++; if (calib_done !== 1'b0) begin failures++; $display("[TB] FAIL to_done_drop: got %b want 0", calib_done); end
        count_state(S_RST, 20, n);
        checks++; if (n != 8) begin failures++; $display("[TB] FAIL to_first_hold: got %0d cycles want 8", n); end
        for (int a = 0; a < 3; a++) begin
            checks++; if (seq_state !== S_CALIB) begin failures++; $display("[TB] FAIL to_calib_state[%0d]: got %0d want %0d", a, seq_state, S_CALIB); end
            checks++; if (retry_cnt !== 2'(a)) begin failures++; $display("[TB] FAIL to_retry[%0d]: got %0d want %0d", a, retry_cnt, a); end
            checks++; if (ctrl_rst !== 1'b0) begin failures++; $display("[TB] FAIL to_calib_ctrl_rst[%0d]: got %b want 0", a, ctrl_rst); end
            count_state(S_CALIB, 150, n);
            checks++; if (n != 100) begin failures++; $display("[TB] FAIL to_window[%0d]: got %0d cycles want 100", a, n); end
            if (a < 2) begin
                checks++; if (retry_cnt !== 2'(a + 1)) begin failures++; $display("[TB] FAIL to_retry_step[%0d]: got %0d want %0d", a, retry_cnt, a + 1); end
                checks++; if (ctrl_rst !== 1'b1) begin failures++; $display("[TB] FAIL to_hold_ctrl_rst[%0d]: got %b want 1", a, ctrl_rst); end
                count_state(S_RST, 20, n);
                checks++; if (n != 8) begin failures++; $display("[TB] FAIL to_hold_len[%0d]: got %0d cycles want 8", a, n); end
            end
        end
        checks++; if (seq_state !== S_FAIL) begin failures++; $display("[TB] FAIL to_fail_state: got %0d want %0d", seq_state, S_FAIL); end
        checks++; if (calib_fail !== 1'b1) begin failures++; $display("[TB] FAIL to_calib_fail: got %b want 1", calib_fail); end
        checks++; if (ctrl_rst !== 1'b1) begin failures++; $display("[TB] FAIL to_fail_ctrl_rst: got %b want 1", ctrl_rst); end
        checks++; if (retry_cnt !== 2'd2) begin failures++; $display("[TB] FAIL to_fail_retry: got %0d want 2", retry_cnt); end
        tick(200);
        checks++; if (seq_state !== S_FAIL || calib_fail !== 1'b1) begin failures++; $display("[TB] FAIL to_fail_hold: got state %0d fail %b want %0d 1", seq_state, calib_fail, S_FAIL); end
    endtask

    task automatic test_recover_fail;
        bit ok;
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        checks++; if (calib_fail !== 1'b0) begin failures++; $display("[TB] FAIL rec_fail_clear: got %b want 0", calib_fail); end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("[TB] FAIL rec_retry_clear: got %0d want 0", retry_cnt); end
        checks++; if (seq_state !== S_RST) begin failures++; $display("[TB] FAIL rec_state: got %0d want %0d", seq_state, S_RST); end
        wait_state(S_CALIB, 20, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL rec_reach_calib: got state %0d want %0d", seq_state, S_CALIB); end
        tick(10);
        phy_init_done = 1'b1;
        tick(1);
        checks++; if (calib_done !== 1'b1) begin failures++; $display("[TB] FAIL rec_calib_done: got %b want 1", calib_done); end
        checks++; if (seq_state !== S_DONE) begin failures++; $display("[TB] FAIL rec_done_state: got %0d want %0d", seq_state, S_DONE); end
        checks++; if (calib_fail !== 1'b0 || retry_cnt !== 2'd0) begin failures++; $display("[TB] FAIL rec_done_status: got fail %b retry %0d want 0 0", calib_fail, retry_cnt); end
    endtask

    task automatic test_simultaneous;
        bit ok;
        int n;
        soft_rst = 1'b1; phy_init_done = 1'b0;
        tick(1);
        soft_rst = 1'b0;
        wait_state(S_CALIB, 20, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL sim_reach_calib: got state %0d want %0d", seq_state, S_CALIB); end
        tick(99);
        phy_init_done = 1'b1;
        tick(1);
        checks++; if (seq_state !== S_DONE) begin failures++; $display("[TB] FAIL sim_done_wins: got state %0d want %0d", seq_state, S_DONE); end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("[TB] FAIL sim_no_retry: got %0d want 0", retry_cnt); end
        idelay_rdy = 1'b0;
        n = 0;
        while (ctrl_rst === 1'b0 && n < 5) begin
            tick(1);
            n++;
        end
        checks++; if (ctrl_rst !== 1'b1 || n > 3) begin failures++; $display("[TB] FAIL sim_idly_drop_rst: got ctrl_rst %b after %0d cycles want 1 within 3", ctrl_rst, n); end
        checks++; if (seq_state !== S_WAIT) begin failures++; $display("[TB] FAIL sim_idly_drop_state: got %0d want %0d", seq_state, S_WAIT); end
        checks++; if (calib_done !== 1'b0) begin failures++; $display("[TB] FAIL sim_idly_drop_done: got %b want 0", calib_done); end
        idelay_rdy = 1'b1;
        wait_state(S_RST, 10, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL sim_reach_hold: got state %0d want %0d", seq_state, S_RST); end
        count_state(S_RST, 20, n);
        checks++; if (n != 8) begin failures++; $display("[TB] FAIL sim_hold_len: got %0d cycles want 8", n); end
        checks++; if (seq_state !== S_CALIB || ctrl_rst !== 1'b0) begin failures++; $display("[TB] FAIL sim_after_hold: got state %0d ctrl_rst %b want %0d 0", seq_state, ctrl_rst, S_CALIB); end
        tick(1);
    endtask

    task automatic test_loss_of_calib;
        bit ok;
        int n;
        soft_rst = 1'b1; phy_init_done = 1'b0;
        tick(1);
        soft_rst = 1'b0;
        wait_state(S_CALIB, 20, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL loss_reach_calib: got state %0d want %0d", seq_state, S_CALIB); end
        count_state(S_CALIB, 150, n);
        wait_state(S_CALIB, 20, ok);
        checks++; if (!ok || retry_cnt !== 2'd1) begin failures++; $display("[TB] FAIL loss_retry_setup: got state %0d retry %0d want %0d 1", seq_state, retry_cnt, S_CALIB); end
        tick(5);
        phy_init_done = 1'b1;
        tick(1);
        checks++; if (seq_state !== S_DONE || calib_done !== 1'b1) begin failures++; $display("[TB] FAIL loss_done: got state %0d done %b want %0d 1", seq_state, calib_done, S_DONE); end
        phy_init_done = 1'b0;
        tick(1);
        checks++; if (calib_done !== 1'b0) begin failures++; $display("[TB] FAIL loss_done_drop: got %b want 0", calib_done); end
        checks++; if (seq_state !== S_RST || ctrl_rst !== 1'b1) begin failures++; $display("[TB] FAIL loss_hold: got state %0d ctrl_rst %b want %0d 1", seq_state, ctrl_rst, S_RST); end
        checks++; if (retry_cnt !== 2'd1) begin failures++; $display("[TB] FAIL loss_retry_kept: got %0d want 1", retry_cnt); end
        count_state(S_RST, 20, n);
        checks++; if (n != 8) begin failures++; $display("[TB] FAIL loss_hold_len: got %0d cycles want 8", n); end
        checks++; if (seq_state !== S_CALIB || retry_cnt !== 2'd1) begin failures++; $display("[TB] FAIL loss_back_calib: got state %0d retry %0d want %0d 1", seq_state, retry_cnt, S_CALIB); end
    endtask

    task automatic test_reset_mid_op;
        int n;
        tick(3);
        #3;
        rst_tmp = 1'b1;
        #1;
        checks++; if (seq_state !== S_PWRUP) begin failures++; $display("[TB] FAIL mid_rst_state: got %0d want %0d", seq_state, S_PWRUP); end
        checks++; if (ctrl_rst !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_ctrl_rst: got %b want 1", ctrl_rst); end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("[TB] FAIL mid_rst_retry: got %0d want 0", retry_cnt); end
        checks++; if (calib_done !== 1'b0 || calib_fail !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_flags: got done %b fail %b want 0 0", calib_done, calib_fail); end
        tick(2);
        rst_tmp = 1'b0;
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        count_state(S_PWRUP, 40, n);
        checks++; if (n + 1 != 16) begin failures++; $display("[TB] FAIL mid_rst_pwrup_len: got %0d cycles want 16", n + 1); end
        checks++; if (seq_state !== S_WAIT) begin failures++; $display("[TB] FAIL mid_rst_next: got %0d want %0d", seq_state, S_WAIT); end
    endtask

    // Scenarios run back to back; each leaves the DUT where the next expects it.
    initial begin
        test_reset();
        test_nominal();
        test_timeout_retries();
        test_recover_fail();
        test_simultaneous();
        test_loss_of_calib();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
